// File: rtl/pipe_hold_sched_pkg.sv
// Shared types and constants for the pipeline hold/flush scheduler.
// Hold codes and scheduler state encodings used by the core and its bench.
package pipe_hold_sched_pkg;

    localparam int INST_ADDR_WIDTH = 32;
    localparam int HOLD_FLAG_WIDTH = 3;

    localparam bit HOLD_ENABLE = 1'b1;
    localparam bit JUMP_ENABLE = 1'b1;

    typedef enum logic [HOLD_FLAG_WIDTH-1:0] {
        HOLD_NONE = 3'b000,
        HOLD_PC   = 3'b001,
        HOLD_IF   = 3'b010,
        HOLD_ID   = 3'b011
    } hold_t;

    typedef enum logic [1:0] {
        SCHED_RUN    = 2'd0,
        SCHED_FLUSH  = 2'd1,
        SCHED_DRAIN  = 2'd2,
        SCHED_HALTED = 2'd3
    } sched_state_t;

endpackage

// File: rtl/pipe_hold_sched_if.sv
// Bundle between ex/rib/clint/jtag, the scheduler and pc_reg/pipeline registers.
// The master side drives requests; the slave side is the scheduler.
interface pipe_hold_sched_if;
    import pipe_hold_sched_pkg::*;

    logic                         jump_flag_i;
    logic [INST_ADDR_WIDTH-1:0]   jump_addr_i;
    logic                         hold_flag_ex_i;
    logic                         hold_flag_rib_i;
    logic                         hold_flag_clint_i;
    logic                         jtag_halt_req_i;
    logic                         jtag_resume_req_i;
    logic [HOLD_FLAG_WIDTH-1:0]   hold_flag_o;
    logic                         jump_flag_o;
    logic [INST_ADDR_WIDTH-1:0]   jump_addr_o;
    logic                         halted_o;
    logic                         rib_timeout_o;

    modport master (
        output jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_rib_i,
               hold_flag_clint_i, jtag_halt_req_i, jtag_resume_req_i,
        input  hold_flag_o, jump_flag_o, jump_addr_o, halted_o, rib_timeout_o
    );

    modport slave (
        input  jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_rib_i,
               hold_flag_clint_i, jtag_halt_req_i, jtag_resume_req_i,
        output hold_flag_o, jump_flag_o, jump_addr_o, halted_o, rib_timeout_o
    );

endinterface

// File: rtl/pipe_hold_wdog.sv
// Rib bus-stall watchdog: counts consecutive rib-hold cycles and emits a
// single registered pulse when the count reaches RIB_TIMEOUT-1.
module pipe_hold_wdog #(
    parameter int RIB_TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic rib_hold,
    output logic timeout
);

    localparam logic [15:0] LIMIT    = 16'(RIB_TIMEOUT - 1);
    localparam logic [15:0] PRE_LIMIT = 16'(RIB_TIMEOUT - 2);

    logic [15:0] cnt;

    // Counter saturates at LIMIT, so PRE_LIMIT is crossed only once per stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 16'd0;
            timeout <= 1'b0;
        end else if (!rib_hold) begin
            cnt     <= 16'd0;
            timeout <= 1'b0;
        end else begin
            timeout <= (cnt == PRE_LIMIT);
            if (cnt != LIMIT) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/pipe_hold_sched.sv
// Pipeline hold/flush scheduler: arbitrates stall sources into one hold code,
// stretches jump flushes and runs the jtag halt/drain/resume handshake.
module pipe_hold_sched
    import pipe_hold_sched_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int RIB_TIMEOUT  = 256
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hold_sched_if.slave   bus
);

    if (FLUSH_CYCLES < 0 || FLUSH_CYCLES > 15) begin : g_bad_flush
        $error("FLUSH_CYCLES out of range 0..15");
    end
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
        $error("DRAIN_CYCLES out of range 1..15");
    end
    if (RIB_TIMEOUT < 2 || RIB_TIMEOUT > 65535) begin : g_bad_timeout
        $error("RIB_TIMEOUT out of range 2..65535");
    end

    localparam bit         FLUSH_EN   = (FLUSH_CYCLES > 0);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    sched_state_t state;
    logic [3:0]   cnt;
    logic         halted;
    hold_t        hold;

    logic jump, ex_hold, rib_hold, clint_hold, halt_req, resume_req;

    assign jump       = (bus.jump_flag_i == JUMP_ENABLE);
    assign ex_hold    = (bus.hold_flag_ex_i == HOLD_ENABLE);
    assign rib_hold   = (bus.hold_flag_rib_i == HOLD_ENABLE);
    assign clint_hold = (bus.hold_flag_clint_i == HOLD_ENABLE);
    assign halt_req   = bus.jtag_halt_req_i;
    assign resume_req = bus.jtag_resume_req_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= SCHED_RUN;
            cnt    <= 4'd0;
            halted <= 1'b0;
        end else begin
            halted <= 1'b0;
            case (state)
                SCHED_RUN: begin
                    // A jump beats a halt; the level halt request is retaken on return.
                    if (jump && FLUSH_EN) begin
                        state <= SCHED_FLUSH;
                        cnt   <= FLUSH_LOAD;
                    end else if (halt_req && !clint_hold) begin
                        state <= SCHED_DRAIN;
                        cnt   <= DRAIN_LOAD;
                    end
                end
                SCHED_FLUSH: begin
                    if (jump) begin
                        cnt <= FLUSH_LOAD;
                    end else if (cnt == 4'd0) begin
                        state <= SCHED_RUN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SCHED_DRAIN: begin
                    if (jump) begin
                        state <= FLUSH_EN ? SCHED_FLUSH : SCHED_RUN;
                        cnt   <= FLUSH_LOAD;
                    end else if (!halt_req) begin
                        state <= SCHED_RUN;
                    end else if (cnt == 4'd0 && !ex_hold && !rib_hold) begin
                        state <= SCHED_HALTED;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SCHED_HALTED: begin
                    if (resume_req) begin
                        state <= SCHED_RUN;
                    end else begin
                        halted <= 1'b1;
                    end
                end
                default: state <= SCHED_RUN;
            endcase
        end
    end

    always_comb begin
        hold = HOLD_NONE;
        if (jump || ex_hold || clint_hold ||
            state == SCHED_FLUSH || state == SCHED_HALTED) begin
            hold = HOLD_ID;
        end else if (rib_hold || state == SCHED_DRAIN) begin
            hold = HOLD_PC;
        end
    end

    pipe_hold_wdog #(
        .RIB_TIMEOUT(RIB_TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .rib_hold (rib_hold),
        .timeout  (bus.rib_timeout_o)
    );

    assign bus.hold_flag_o = hold;
    assign bus.jump_flag_o = jump;
    assign bus.jump_addr_o = bus.jump_addr_i;
    assign bus.halted_o    = halted;

endmodule

// File: tb/tb_pipe_hold_sched.sv
// Bench for pipe_hold_sched with FLUSH_CYCLES=2, DRAIN_CYCLES=3, RIB_TIMEOUT=8.
module tb_pipe_hold_sched;
    import pipe_hold_sched_pkg::*;

    typedef struct {
        string       name;
        logic        rst;
        logic        jump;
        logic [31:0] addr;
        logic        ex;
        logic        rib;
        logic        clint;
        logic        halt;
        logic        resume;
        logic [2:0]  hold;
        logic        halted;
        logic        to;
    } vec_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    pipe_hold_sched_if bus ();

    pipe_hold_sched #(
        .FLUSH_CYCLES (2),
        .DRAIN_CYCLES (3),
        .RIB_TIMEOUT  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic r, input logic j, input logic [31:0] a,
                       input logic ex, input logic rib, input logic cl, input logic ht,
                       input logic rs, input logic [2:0] h, input logic hd, input logic to);
        vec_t v;
        v.name = n; v.rst = r; v.jump = j; v.addr = a; v.ex = ex; v.rib = rib;
        v.clint = cl; v.halt = ht; v.resume = rs; v.hold = h; v.halted = hd; v.to = to;
        vecs.push_back(v);
    endtask

    task automatic set_in(input logic j, input logic [31:0] a, input logic ex, input logic rib,
                          input logic cl, input logic ht, input logic rs);
        bus.jump_flag_i       = j;
        bus.jump_addr_i       = a;
        bus.hold_flag_ex_i    = ex;
        bus.hold_flag_rib_i   = rib;
        bus.hold_flag_clint_i = cl;
        bus.jtag_halt_req_i   = ht;
        bus.jtag_resume_req_i = rs;
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        string tag;
        rst = v.rst;
        set_in(v.jump, v.addr, v.ex, v.rib, v.clint, v.halt, v.resume);
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        tag = $sformatf("%s[%0d]", e.name, idx);
        check({tag, ".hold"},   32'(bus.hold_flag_o),   32'(e.hold));
        check({tag, ".halted"}, 32'(bus.halted_o),      32'(e.halted));
        check({tag, ".tmo"},    32'(bus.rib_timeout_o), 32'(e.to));
        check({tag, ".jump"},   32'(bus.jump_flag_o),   32'(e.jump));
        check({tag, ".addr"},   bus.jump_addr_o,        e.addr);
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        rst = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        //   name         rst jmp addr     ex rib cl halt res hold       hd to
        add("reset",      0, 0, 32'h0,   0, 0, 0, 0, 0, HOLD_NONE, 0, 0);
        add("reset",      0, 0, 32'h0,   0, 0, 0, 0, 0, HOLD_NONE, 0, 0);
        for (int i = 0; i < 3; i++)
            add("idle",   1, 0, 32'h0,   0, 0, 0, 0, 0, HOLD_NONE, 0, 0);
        add("jmp",        1, 1, 32'h100, 0, 0, 0, 0, 0, HOLD_ID,   0, 0);
        add("flush",      1, 0, 32'h0,   0, 0, 0, 0, 0, HOLD_ID,   0, 0);
        add("flush",      1, 0, 32'h0,   0, 0, 0, 0, 0, HOLD_ID,   0, 0);
        add("flush_end",  1, 0, 32'h0,   0, 0, 0, 0, 0, HOLD_NONE, 0, 0);
        add("jmp2a",      1, 1, 32'h200, 0, 0, 0, 0, 0, HOLD_ID,   0, 0);
        add("jmp2b",      1, 1, 32'h204, 0, 0, 0, 0, 0, HOLD_ID,   0, 0);
        add("flush_ext",  1, 0, 32'h0,   0, 0, 0, 0, 0, HOLD_ID,   0, 0);
        add("flush_ext",  1, 0, 32'h0,   0, 0, 0, 0, 0, HOLD_ID,   0, 0);
        add("flush_ext_e",1, 0, 32'h0,   0, 0, 0, 0, 0, HOLD_NONE, 0, 0);
        add("halt_run",   1, 0, 32'h0,   0, 0, 0, 1, 0, HOLD_NONE, 0, 0);
        for (int i = 0; i < 3; i++)
            add("drain",  1, 0, 32'h0,   0, 0, 0, 1, 0, HOLD_PC,   0, 0);
        add("halt_entry", 1, 0, 32'h0,   0, 0, 0, 1, 0, HOLD_ID,   0, 0);
        add("halted",     1, 0, 32'h0,   0, 0, 0, 1, 0, HOLD_ID,   1, 0);
        add("resume",     1, 0, 32'h0,   0, 0, 0, 0, 1, HOLD_ID,   1, 0);
        add("post_resume",1, 0, 32'h0,   0, 0, 0, 0, 0, HOLD_NONE, 0, 0);
        for (int i = 0; i < 4; i++)
            add("clint",  1, 0, 32'h0,   0, 0, 1, 1, 0, HOLD_ID,   0, 0);
        add("clint_drop", 1, 0, 32'h0,   0, 0, 0, 1, 0, HOLD_NONE, 0, 0);
        for (int i = 0; i < 3; i++)
            add("cl_drain",1,0, 32'h0,   0, 0, 0, 1, 0, HOLD_PC,   0, 0);
        add("cl_hentry",  1, 0, 32'h0,   0, 0, 0, 0, 1, HOLD_ID,   0, 0);
        add("cl_post",    1, 0, 32'h0,   0, 0, 0, 0, 0, HOLD_NONE, 0, 0);
        add("jd_run",     1, 0, 32'h0,   0, 0, 0, 1, 0, HOLD_NONE, 0, 0);
        add("jd_drain0",  1, 0, 32'h0,   0, 0, 0, 1, 0, HOLD_PC,   0, 0);
        add("jd_jump",    1, 1, 32'h300, 0, 0, 0, 1, 0, HOLD_ID,   0, 0);
        add("jd_flush",   1, 0, 32'h0,   0, 0, 0, 1, 0, HOLD_ID,   0, 0);
        add("jd_flush",   1, 0, 32'h0,   0, 0, 0, 1, 0, HOLD_ID,   0, 0);
        add("jd_rerun",   1, 0, 32'h0,   0, 0, 0, 1, 0, HOLD_NONE, 0, 0);
        add("jd_redrain", 1, 0, 32'h0,   0, 0, 0, 1, 0, HOLD_PC,   0, 0);
        add("jd_drop",    1, 0, 32'h0,   0, 0, 0, 0, 0, HOLD_PC,   0, 0);
        add("jd_idle",    1, 0, 32'h0,   0, 0, 0, 0, 0, HOLD_NONE, 0, 0);
        for (int i = 1; i <= 20; i++)
            add("wd_run1",1, 0, 32'h0,   0, 1, 0, 0, 0, HOLD_PC,   0, logic'(i == 8));
        add("wd_gap",     1, 0, 32'h0,   0, 0, 0, 0, 0, HOLD_NONE, 0, 0);
        for (int i = 1; i <= 12; i++)
            add("wd_run2",1, 0, 32'h0,   0, 1, 0, 0, 0, HOLD_PC,   0, logic'(i == 8));
        add("wd_jump",    1, 1, 32'h500, 0, 1, 0, 0, 0, HOLD_ID,   0, 0);
        add("wd_rst",     0, 0, 32'h0,   0, 1, 0, 0, 0, HOLD_PC,   0, 0);
        for (int i = 1; i <= 10; i++)
            add("wd_run3",1, 0, 32'h0,   0, 1, 0, 0, 0, HOLD_PC,   0, logic'(i == 8));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // Halt stretched by ex: drain counter saturates, then halt lands once ex drops.
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("hs_idle.hold", 32'(bus.hold_flag_o), 32'(HOLD_NONE));
        tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("hs_ex[%0d].hold", k), 32'(bus.hold_flag_o), 32'(HOLD_ID));
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        seen = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.halted_o) begin
                seen = k;
                break;
            end
            tick();
        end
        check("hs_halt_latency", 32'(seen), 32'd2);
        tick();
        set_in(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("hs_jmp_halted.hold",  32'(bus.hold_flag_o), 32'(HOLD_ID));
        check("hs_jmp_halted.jump",  32'(bus.jump_flag_o), 32'd1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("hs_still_halted", 32'(bus.halted_o),    32'd1);
        check("hs_still_hold",   32'(bus.hold_flag_o), 32'(HOLD_ID));
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("hs_resumed.halted", 32'(bus.halted_o),    32'd0);
        check("hs_resumed.hold",   32'(bus.hold_flag_o), 32'(HOLD_NONE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hold_sched.md
Name: pipe_hold_sched

Overview:
- Sequential pipeline hold/flush scheduler for the core. It arbitrates stall requests from ex, rib, clint and jtag into one hold code for pc_reg/if_id/id_ex.
- It stretches jump flushes over a configurable window and runs a debug halt/drain/resume handshake with jtag.
- A rib bus-stall watchdog flags a stuck bus.
- It sits between ex/rib/clint/jtag and pc_reg plus the pipeline registers, replacing the purely combinational hold arbitration.

Parameters:
- FLUSH_CYCLES, 2: extra cycles Hold_Id is held after a jump (0..15).
- DRAIN_CYCLES, 3: cycles fetch is held at Hold_Pc before the core is reported halted (1..15).
- RIB_TIMEOUT, 256: consecutive rib-hold cycles that trigger the watchdog (2..65535).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- jump_flag_i  in  1  jump request from ex.
- jump_addr_i  in  `INST_ADDR_WIDTH  jump target from ex.
- hold_flag_ex_i  in  1  ex multi-cycle hold (div).
- hold_flag_rib_i  in  1  bus busy hold.
- hold_flag_clint_i  in  1  interrupt-entry hold.
- jtag_halt_req_i  in  1  level halt request.
- jtag_resume_req_i  in  1  single-cycle resume pulse.
- hold_flag_o  out  `Hold_Flag_Bus  hold code to pc_reg/if_id/id_ex.
- jump_flag_o  out  1  jump to pc_reg.
- jump_addr_o  out  `INST_ADDR_WIDTH  jump target to pc_reg.
- halted_o  out  1  core halted ack to jtag.
- rib_timeout_o  out  1  one-cycle watchdog pulse.

Behaviour:
- Reset: asynchronous on rst low; state=RUN, counters=0; halted_o=0, rib_timeout_o=0, hold_flag_o=Hold_None, jump_flag_o=0, jump_addr_o=0.
- jump_flag_o and jump_addr_o are a zero-latency combinational pass-through of jump_flag_i and jump_addr_i; pc_reg redirects in the same cycle.
- hold_flag_o is combinational from the current state plus the live inputs.
- Hold priority, highest first:
  - jump_flag_i | hold_flag_ex_i | hold_flag_clint_i | state==FLUSH | state==HALTED -> Hold_Id.
  - else hold_flag_rib_i | state==DRAIN -> Hold_Pc.
  - else Hold_None.
- FSM states: RUN, FLUSH, DRAIN, HALTED.
- RUN:
  - jump_flag_i & FLUSH_CYCLES>0 -> FLUSH, with cnt=FLUSH_CYCLES-1.
  - else jtag_halt_req_i & !hold_flag_clint_i -> DRAIN, with cnt=DRAIN_CYCLES-1.
  - A jump and a halt request in the same cycle: the jump wins. The halt request is still pending (level signal) and is taken on the RUN re-entry.
- FLUSH:
  - A new jump_flag_i reloads cnt=FLUSH_CYCLES-1.
  - cnt==0 -> RUN; else cnt decrements.
- DRAIN:
  - jump_flag_i -> FLUSH (reload), abandoning the drain.
  - jtag_halt_req_i deasserted -> RUN.
  - cnt==0 & !hold_flag_ex_i & !hold_flag_rib_i -> HALTED.
  - cnt decrements saturating at 0.
- HALTED:
  - halted_o=1, registered; it rises on the cycle after HALTED is entered.
  - jtag_resume_req_i -> RUN; halted_o=0 on the next cycle.
  - jump_flag_i is ignored for state transitions in HALTED; ex cannot legally issue a jump while held.
- Interrupt vs. halt: hold_flag_clint_i blocks the RUN->DRAIN transition, so an interrupt entry completes before a halt.
- Watchdog: a 16-bit counter increments while hold_flag_rib_i=1 and clears when it is 0. On reaching RIB_TIMEOUT-1:
  - rib_timeout_o pulses for exactly one cycle.
  - The counter then saturates and does not re-pulse until hold_flag_rib_i drops.
  - The watchdog runs in every state.
- Reset mid-operation: an immediate return to the reset values above; any in-progress flush or drain is lost.
- Width rules: cnt is 4 bits and the watchdog counter is 16 bits. Both are loaded from the parameters truncated to their width; parameter ranges are checked by an elaboration assertion.

Decomposition:
- Shared defines, extending the existing defines file:
  - Hold codes: Hold_None=3'b000, Hold_Pc=3'b001, Hold_If=3'b010, Hold_Id=3'b011.
  - HoldEnable=1'b1, JumpEnable=1'b1.
  - FSM state encodings: SCHED_RUN/FLUSH/DRAIN/HALTED, 2 bits.
- One natural sub-module: pipe_hold_wdog, holding the rib watchdog counter and pulse generation.
- FSM, counters and priority mux stay in the top.

Test Plan:
- Reset then idle: after rst rises with all inputs 0, hold_flag_o=3'b000, halted_o=0 and rib_timeout_o=0 every cycle.
- Jump flush with FLUSH_CYCLES=2: jump_flag_i=1 with addr 0x100 for 1 cycle -> jump_flag_o=1 and addr 0x100 in the same cycle, hold_flag_o=Hold_Id for 3 cycles total, then Hold_None. A second jump in flush cycle 1 extends Hold_Id by 2 more cycles.
- Halt/resume with DRAIN_CYCLES=3: jtag_halt_req_i held -> Hold_Pc for 3 cycles, then Hold_Id, with halted_o=1 one cycle after HALTED is entered. A resume pulse -> halted_o=0 and Hold_None next cycle.
- Halt during clint hold: hold_flag_clint_i=1 for 4 cycles with halt_req=1 -> Hold_Id throughout and no DRAIN entry until clint drops; drain then starts.
- Jump during drain: jump at drain cycle 1 -> FLUSH for FLUSH_CYCLES, back to RUN, then re-enter DRAIN because halt_req is still high.
- Watchdog with RIB_TIMEOUT=8: hold_flag_rib_i=1 for 20 cycles -> Hold_Pc throughout, a single rib_timeout_o pulse at cycle 8, none after. Drop rib for 1 cycle and raise it again -> a new pulse 8 cycles later. Asserting rst mid-count clears everything.
